lcd_show_glyph_scaled: RTL and testbench
========================================

// Module: lcd_show_glyph_scaled
// PURPOSE
//  Renders one ASCII glyph on the st7735 SPI-LCD. The glyph comes from an external font ROM, has
//  run-time fg/bg colours and integer magnification 1..4. It sets the CASET/RASET/RAMWR window,
//  then streams RGB565 pixels as 9-bit {DC,byte} words to the SPI writer, one word per
//  en_write/wr_done transaction. It sits between the text/menu controller and the SPI writer.
//  Replaces fixed-font/fixed-colour char drawing.
// PARAMETERS
//  FONT_W       8     glyph width in pixels, 1..8; ROM byte bit0 = leftmost column
//  FONT_H       16    glyph height, rows = ROM bytes per glyph, 1..32
//  ROM_BASE     1140  ROM address of the glyph for ASCII_FIRST
//  ROM_AW       12    ROM address width
//  ROM_LAT      1     ROM read latency in sys_clk cycles, 1..3
//  ASCII_FIRST  32    first code present in ROM
//  ASCII_LAST   126   last code present in ROM
//  ASCII_SUBST  63    code drawn when ascii_num is out of range ('?')
//  LCD_W/LCD_H  128/160  panel size, used for bounds check
// PORTS
//  sys_clk     in   1        clock
//  sys_rst_n   in   1        async active-low reset
//  start       in   1        draw request, sampled only in IDLE
//  ascii_num   in   7        character code
//  start_x     in   9        window left column
//  start_y     in   9        window top row
//  scale       in   2        magnification-1 (0 -> x1 .. 3 -> x4)
//  fg_color    in   16       RGB565 for set bits
//  bg_color    in   16       RGB565 for clear bits
//  rom_addr    out  ROM_AW   font ROM address
//  rom_q       in   8        font ROM data, valid ROM_LAT cycles after rom_addr
//  lcd_data    out  9        bit8=DC (0 cmd, 1 data), bits7:0 byte
//  en_write    out  1        lcd_data valid, request to SPI writer
//  wr_done     in   1        1-cycle pulse: current word consumed
//  busy        out  1        operation in progress
//  done        out  1        1-cycle completion pulse
//  err         out  1        valid with done: request rejected
// BEHAVIOUR
//  Clock sys_clk; reset sys_rst_n asynchronous, active-low.
//  - Reset: all outputs 0, state IDLE. Reset mid-draw aborts at once and emits no done.
//  - Accepting start in IDLE latches all inputs. busy rises the next cycle and stays high through
//    the done cycle. start while busy is ignored.
//  - S = scale+1. end_x = start_x + FONT_W*S - 1; end_y = start_y + FONT_H*S - 1 (10-bit math).
//    If end_x >= LCD_W or end_y >= LCD_H: go to DONE with err=1 and write nothing.
//  - Glyph index g = ascii_num if ASCII_FIRST <= ascii_num <= ASCII_LAST, else ASCII_SUBST.
//    rom_addr = ROM_BASE + (g - ASCII_FIRST)*FONT_H + row.
//  - FSM: IDLE -> CHECK -> WIN -> FETCH -> PIXEL -> (FETCH | DONE) -> IDLE.
//  - WIN: 11 words, each held with en_write=1 until its wr_done.
//    Order: 0x02A, {1,7'b0,sx[8]}, {1,sx[7:0]}, {1,7'b0,ex[8]}, {1,ex[7:0]}, 0x02B,
//    same four for y, 0x02C.
//  - en_write rises the cycle after start for the first (valid) word. The next word is on
//    lcd_data the cycle after wr_done. en_write may stay high across words.
//  - FETCH: en_write=0. Drive rom_addr, wait ROM_LAT cycles, latch rom_q into the row register.
//  - PIXEL: per row, S vertical repeats; per repeat, FONT_W columns; each column S times.
//    Each pixel = 2 words, {1,colour[15:8]} then {1,colour[7:0]}; colour = bit ? fg : bg.
//    The row register is reused for all S repeats (one ROM read per glyph row).
//  - Total words = 11 + 2*FONT_W*FONT_H*S^2.
//  - After the last pixel word's wr_done: DONE for 1 cycle (done=1, busy=1, en_write=0), then IDLE.
//  - wr_done while en_write=0 is ignored. Simultaneous start and done never overlap
//    (start is ignored in DONE).
//  - Columns FONT_W..7 of the ROM byte are never drawn.
// TESTING
//  1 'A'(65), (10,20), S=1, fg=FFE0, bg=0010 -> window x 10..17, y 20..35; 267 words;
//    first pixel words match ROM[1140+33*16] bit0.
//  2 Same, scale=1 -> x 10..25, y 20..51; 1035 words; every column pair and row pair identical.
//  3 ascii_num=127 and 5 -> glyph '?' (rom_addr base 1140+31*16); done=1, err=0.
//  4 start_x=121, FONT_W=8, S=1 -> end_x 128 >= 128 -> done=1, err=1, en_write never high.
//  5 wr_done stalled 0..7 random cycles, ROM_LAT=3 -> identical word sequence; start pulses
//    while busy are ignored.
//  6 sys_rst_n low mid-PIXEL -> outputs 0 immediately, no done. Next start draws a full,
//    correct glyph.

Source files
------------

// File: rtl/lcd_show_glyph_scaled.sv
// Draws one scaled ASCII glyph on an st7735 panel: window setup, then
// RGB565 pixel stream as {DC,byte} words, one per en_write/wr_done handshake.
module lcd_show_glyph_scaled #(
  parameter int FONT_W      = 8,
  parameter int FONT_H      = 16,
  parameter int ROM_BASE    = 1140,
  parameter int ROM_AW      = 12,
  parameter int ROM_LAT     = 1,
  parameter int ASCII_FIRST = 32,
  parameter int ASCII_LAST  = 126,
  parameter int ASCII_SUBST = 63,
  parameter int LCD_W       = 128,
  parameter int LCD_H       = 160
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [6:0]        ascii_num,
  input  logic [8:0]        start_x,
  input  logic [8:0]        start_y,
  input  logic [1:0]        scale,
  input  logic [15:0]       fg_color,
  input  logic [15:0]       bg_color,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  output logic [8:0]        lcd_data,
  output logic              en_write,
  input  logic              wr_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_WIN   = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_PIXEL = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        r_state;
  logic [8:0]        r_sx;
  logic [8:0]        r_sy;
  logic [8:0]        r_ex;
  logic [8:0]        r_ey;
  logic [1:0]        r_sc;
  logic [15:0]       r_fg;
  logic [15:0]       r_bg;
  logic [ROM_AW-1:0] r_base;
  logic              r_bad;
  logic [7:0]        r_bits;
  logic [3:0]        r_wi;
  logic [1:0]        r_wait;
  logic [4:0]        r_row;
  logic [1:0]        r_vrep;
  logic [2:0]        r_col;
  logic [1:0]        r_hrep;
  logic              r_half;
  logic [8:0]        r_data;
  logic              r_en;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [2:0]        w_s;
  logic [9:0]        w_ex;
  logic [9:0]        w_ey;
  logic              w_bad;
  logic [6:0]        w_g;
  logic [ROM_AW-1:0] w_base;
  logic [15:0]       w_cur;
  logic [15:0]       w_nxt;
  logic [15:0]       w_c0;
  logic [15:0]       w_first;
  logic              w_hs;

  assign w_s   = {1'b0, scale} + 3'd1;
  assign w_ex  = {1'b0, start_x}
               + 10'(FONT_W) * {7'd0, w_s} - 10'd1;
  assign w_ey  = {1'b0, start_y}
               + 10'(FONT_H) * {7'd0, w_s} - 10'd1;
  assign w_bad = (w_ex >= 10'(LCD_W)) || (w_ey >= 10'(LCD_H));

  assign w_g = (ascii_num >= 7'(ASCII_FIRST) &&
                ascii_num <= 7'(ASCII_LAST)) ?
               ascii_num : 7'(ASCII_SUBST);
  assign w_base = ROM_AW'(ROM_BASE +
                  (int'(w_g) - ASCII_FIRST) * FONT_H);

  assign rom_addr = r_base + ROM_AW'(r_row);

  function automatic logic [15:0] f_col(
    input logic [7:0] bits,
    input logic [2:0] col
  );
    return bits[col] ? r_fg : r_bg;
  endfunction

  function automatic logic [8:0] f_win(input logic [3:0] i);
    case (i)
      4'd0:    return 9'h02A;
      4'd1:    return {8'h80, r_sx[8]};
      4'd2:    return {1'b1, r_sx[7:0]};
      4'd3:    return {8'h80, r_ex[8]};
      4'd4:    return {1'b1, r_ex[7:0]};
      4'd5:    return 9'h02B;
      4'd6:    return {8'h80, r_sy[8]};
      4'd7:    return {1'b1, r_sy[7:0]};
      4'd8:    return {8'h80, r_ey[8]};
      4'd9:    return {1'b1, r_ey[7:0]};
      default: return 9'h02C;
    endcase
  endfunction

  assign w_cur   = f_col(r_bits, r_col);
  assign w_nxt   = f_col(r_bits, r_col + 3'd1);
  assign w_c0    = f_col(r_bits, 3'd0);
  assign w_first = rom_q[0] ? r_fg : r_bg;
  assign w_hs    = r_en && wr_done;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_sx    <= '0;
      r_sy    <= '0;
      r_ex    <= '0;
      r_ey    <= '0;
      r_sc    <= '0;
      r_fg    <= '0;
      r_bg    <= '0;
      r_base  <= '0;
      r_bad   <= 1'b0;
      r_bits  <= '0;
      r_wi    <= '0;
      r_wait  <= '0;
      r_row   <= '0;
      r_vrep  <= '0;
      r_col   <= '0;
      r_hrep  <= '0;
      r_half  <= 1'b0;
      r_data  <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sx    <= start_x;
            r_sy    <= start_y;
            r_ex    <= w_ex[8:0];
            r_ey    <= w_ey[8:0];
            r_sc    <= scale;
            r_fg    <= fg_color;
            r_bg    <= bg_color;
            r_base  <= w_base;
            r_bad   <= w_bad;
            r_wi    <= '0;
            r_row   <= '0;
            r_vrep  <= '0;
            r_col   <= '0;
            r_hrep  <= '0;
            r_half  <= 1'b0;
            r_busy  <= 1'b1;
            // First window word goes out while CHECK settles the verdict
            r_en    <= ~w_bad;
            r_data  <= w_bad ? 9'h000 : 9'h02A;
            r_state <= S_CHECK;
          end
        end
        S_CHECK, S_WIN: begin
          if (r_bad) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_WIN;
            if (w_hs) begin
              if (r_wi == 4'd10) begin
                r_en    <= 1'b0;
                r_wait  <= '0;
                r_state <= S_FETCH;
              end else begin
                r_wi   <= r_wi + 4'd1;
                r_data <= f_win(r_wi + 4'd1);
              end
            end
          end
        end
        S_FETCH: begin
          if (r_wait == 2'(ROM_LAT)) begin
            r_bits  <= rom_q;
            r_data  <= {1'b1, w_first[15:8]};
            r_en    <= 1'b1;
            r_half  <= 1'b0;
            r_state <= S_PIXEL;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_PIXEL: begin
          if (w_hs) begin
            if (!r_half) begin
              r_half <= 1'b1;
              r_data <= {1'b1, w_cur[7:0]};
            end else begin
              r_half <= 1'b0;
              if (r_hrep != r_sc) begin
                r_hrep <= r_hrep + 2'd1;
                r_data <= {1'b1, w_cur[15:8]};
              end else if (r_col != 3'(FONT_W - 1)) begin
                r_hrep <= '0;
                r_col  <= r_col + 3'd1;
                r_data <= {1'b1, w_nxt[15:8]};
              end else if (r_vrep != r_sc) begin
                r_hrep <= '0;
                r_col  <= '0;
                r_vrep <= r_vrep + 2'd1;
                r_data <= {1'b1, w_c0[15:8]};
              end else begin
                r_hrep <= '0;
                r_col  <= '0;
                r_vrep <= '0;
                r_en   <= 1'b0;
                if (r_row == 5'(FONT_H - 1)) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_row   <= r_row + 5'd1;
                  r_wait  <= '0;
                  r_state <= S_FETCH;
                end
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign lcd_data = r_data;
  assign en_write = r_en;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_lcd_show_glyph_scaled.sv
// Scoreboard bench for lcd_show_glyph_scaled: expected words and done
// results are queued at issue time and checked by an independent monitor.
module tb_lcd_show_glyph_scaled;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  ascii_num = '0;
  logic [8:0]  start_x = '0;
  logic [8:0]  start_y = '0;
  logic [1:0]  scale = '0;
  logic [15:0] fg_color = '0;
  logic [15:0] bg_color = '0;
  logic [11:0] rom_addr;
  logic [7:0]  rom_q;
  logic [8:0]  lcd_data;
  logic        en_write;
  logic        wr_done = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic err;
    int   n;
  } dexp_t;

  logic [8:0] exp_q[$];
  dexp_t      done_q[$];
  int         total = 0;
  int         bad = 0;
  int         nwords = 0;
  int         stall_max = 0;
  logic [7:0] p1, p2;

  always #5 sys_clk = ~sys_clk;

  lcd_show_glyph_scaled #(.ROM_LAT(3)) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .ascii_num (ascii_num),
    .start_x   (start_x),
    .start_y   (start_y),
    .scale     (scale),
    .fg_color  (fg_color),
    .bg_color  (bg_color),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .lcd_data  (lcd_data),
    .en_write  (en_write),
    .wr_done   (wr_done),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  function automatic logic [7:0] rom_byte(input logic [11:0] a);
    logic [7:0] v;
    v = a[7:0] * 8'd37;
    return v ^ {a[11:8], a[3:0]};
  endfunction

  // Font ROM with three cycles of read latency
  always @(posedge sys_clk) begin
    p1    <= rom_byte(rom_addr);
    p2    <= p1;
    rom_q <= p2;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  // SPI writer model: optional stall, one-cycle wr_done pulses
  initial begin : resp
    int d;
    d = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (!sys_rst_n) begin
        wr_done = 1'b0;
        d = 0;
      end else if (wr_done) begin
        wr_done = 1'b0;
      end else if (en_write) begin
        if (d == 0) begin
          wr_done = 1'b1;
          d = $urandom_range(0, stall_max);
        end else begin
          d--;
        end
      end else if (stall_max > 0 &&
                   $urandom_range(0, 3) == 0) begin
        wr_done = 1'b1;
      end
    end
  end

  always @(negedge sys_clk) begin : mon
    logic [8:0] e;
    dexp_t      dx;
    if (en_write && wr_done) begin
      nwords++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL word_unexpected got=%h", lcd_data);
      end else begin
        e = exp_q.pop_front();
        chk("word", 32'(lcd_data), 32'(e));
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected err=%b", err);
      end else begin
        dx = done_q.pop_front();
        chk("err", 32'(err), 32'(dx.err));
        chk("word_count", nwords, dx.n);
        chk("busy_in_done", 32'(busy), 1);
      end
      nwords = 0;
    end
  end

  task automatic push_win(input logic [8:0] sx, input logic [8:0] ex,
                          input logic [8:0] sy, input logic [8:0] ey);
    exp_q.push_back(9'h02A);
    exp_q.push_back({8'h80, sx[8]});
    exp_q.push_back({1'b1, sx[7:0]});
    exp_q.push_back({8'h80, ex[8]});
    exp_q.push_back({1'b1, ex[7:0]});
    exp_q.push_back(9'h02B);
    exp_q.push_back({8'h80, sy[8]});
    exp_q.push_back({1'b1, sy[7:0]});
    exp_q.push_back({8'h80, ey[8]});
    exp_q.push_back({1'b1, ey[7:0]});
    exp_q.push_back(9'h02C);
  endtask

  task automatic push_pix(input int g, input int sc,
                          input logic [15:0] fg,
                          input logic [15:0] bg);
    logic [7:0]  b;
    logic [15:0] c;
    for (int r = 0; r < 16; r++) begin
      b = rom_byte(12'(1140 + (g - 32) * 16 + r));
      for (int v = 0; v <= sc; v++)
        for (int x = 0; x < 8; x++)
          for (int h = 0; h <= sc; h++) begin
            c = b[x] ? fg : bg;
            exp_q.push_back({1'b1, c[15:8]});
            exp_q.push_back({1'b1, c[7:0]});
          end
    end
  endtask

  task automatic push_done(input logic e, input int n);
    dexp_t dx;
    dx.err = e;
    dx.n   = n;
    done_q.push_back(dx);
  endtask

  task automatic issue(input logic [6:0] a, input int sx,
                       input int sy, input logic [1:0] sc,
                       input logic [15:0] fg,
                       input logic [15:0] bg,
                       input logic exp_bad);
    @(posedge sys_clk);
    #1;
    ascii_num = a;
    start_x   = 9'(sx);
    start_y   = 9'(sy);
    scale     = sc;
    fg_color  = fg;
    bg_color  = bg;
    start     = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    chk("busy_rise", 32'(busy), 1);
    chk("en_first", 32'(en_write), 32'(!exp_bad));
  endtask

  task automatic wait_done(input int limit, input bit pulse);
    for (int i = 0; i < limit; i++) begin
      @(posedge sys_clk);
      #1;
      if (done) begin
        start = pulse;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        chk("busy_fall", 32'(busy), 0);
        chk("idle_en", 32'(en_write), 0);
        return;
      end
      if (pulse) begin
        start     = 1'($urandom_range(0, 1));
        start_x   = 9'($urandom_range(0, 300));
        ascii_num = 7'($urandom_range(0, 127));
      end
    end
    start = 1'b0;
    total++;
    bad++;
    $display("FAIL done_timeout got=no_done want=done");
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_en", 32'(en_write), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_data", 32'(lcd_data), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // 'A' at (10,20), x1
    push_win(9'd10, 9'd17, 9'd20, 9'd35);
    push_pix(65, 0, 16'hFFE0, 16'h0010);
    push_done(1'b0, 267);
    issue(7'd65, 10, 20, 2'd0, 16'hFFE0, 16'h0010, 1'b0);
    wait_done(3000, 1'b0);

    // 'A' at (10,20), x2
    push_win(9'd10, 9'd25, 9'd20, 9'd51);
    push_pix(65, 1, 16'hFFE0, 16'h0010);
    push_done(1'b0, 1035);
    issue(7'd65, 10, 20, 2'd1, 16'hFFE0, 16'h0010, 1'b0);
    wait_done(10000, 1'b0);

    // Out-of-range codes draw '?'
    push_win(9'd0, 9'd7, 9'd0, 9'd15);
    push_pix(63, 0, 16'h1234, 16'hABCD);
    push_done(1'b0, 267);
    issue(7'd127, 0, 0, 2'd0, 16'h1234, 16'hABCD, 1'b0);
    wait_done(3000, 1'b0);
    push_win(9'd100, 9'd107, 9'd140, 9'd155);
    push_pix(63, 0, 16'hF800, 16'h07E0);
    push_done(1'b0, 267);
    issue(7'd5, 100, 140, 2'd0, 16'hF800, 16'h07E0, 1'b0);
    wait_done(3000, 1'b0);

    // Bounds: rejected windows, then the largest legal corner
    push_done(1'b1, 0);
    issue(7'd66, 121, 0, 2'd0, 16'hFFFF, 16'h0000, 1'b1);
    wait_done(20, 1'b0);
    push_done(1'b1, 0);
    issue(7'd66, 0, 145, 2'd0, 16'hFFFF, 16'h0000, 1'b1);
    wait_done(20, 1'b0);
    push_done(1'b1, 0);
    issue(7'd66, 100, 0, 2'd3, 16'hFFFF, 16'h0000, 1'b1);
    wait_done(20, 1'b0);
    push_win(9'd120, 9'd127, 9'd144, 9'd159);
    push_pix(90, 0, 16'h5555, 16'hAAAA);
    push_done(1'b0, 267);
    issue(7'd90, 120, 144, 2'd0, 16'h5555, 16'hAAAA, 1'b0);
    wait_done(3000, 1'b0);

    // Stalled writer, spurious wr_done, start pulses while busy
    stall_max = 7;
    push_win(9'd30, 9'd37, 9'd40, 9'd55);
    push_pix(103, 0, 16'h0F0F, 16'hF0F0);
    push_done(1'b0, 267);
    issue(7'd103, 30, 40, 2'd0, 16'h0F0F, 16'hF0F0, 1'b0);
    wait_done(10000, 1'b1);
    stall_max = 0;

    // Reset mid-pixel, then a clean redraw
    push_win(9'd10, 9'd17, 9'd20, 9'd35);
    push_pix(65, 0, 16'hFFE0, 16'h0010);
    push_done(1'b0, 267);
    issue(7'd65, 10, 20, 2'd0, 16'hFFE0, 16'h0010, 1'b0);
    for (int i = 0; i < 2000 && nwords < 60; i++)
      @(posedge sys_clk);
    chk("reached_pixels", 32'(nwords >= 60), 1);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("abort_en", 32'(en_write), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_data", 32'(lcd_data), 0);
    exp_q.delete();
    done_q.delete();
    nwords = 0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    push_win(9'd10, 9'd17, 9'd20, 9'd35);
    push_pix(65, 0, 16'hFFE0, 16'h0010);
    push_done(1'b0, 267);
    issue(7'd65, 10, 20, 2'd0, 16'hFFE0, 16'h0010, 1'b0);
    wait_done(3000, 1'b0);

    repeat (4) @(posedge sys_clk);
    chk("words_left", exp_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
